speaker_arbiter: RTL and testbench

Shares the single PWM speaker between the tuner, metronome and composer tone sources. It picks one winner from the sources that the current mode allows, and inserts a muted gap whenever ownership changes so mode switches and preemption never click. It drives the speaker's freq/h inputs and the amplifier enable pin. It sits between the three tone engines and the speaker instance in the top level, replacing the plain mode multiplexer.

---
 rtl/speaker_arbiter_pkg.sv | 41 ++++
 rtl/speaker_arbiter_gap_timer.sv | 29 ++
 rtl/speaker_arbiter.sv | 127 ++++++++++++
 tb/tb_speaker_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/speaker_arbiter_pkg.sv
// Shared encodings and helpers for the speaker arbiter: modes, source indices,
// rest tone and FSM states.
package speaker_arbiter_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_TUNER = 2'b01,
    MODE_METRO = 2'b10,
    MODE_COMP  = 2'b11
  } mode_e;

  localparam logic [1:0] SRC_T = 2'd0;
  localparam logic [1:0] SRC_M = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;

  localparam logic [3:0] REST_FREQ_DEF = 4'hC;
  localparam logic [2:0] REST_H_DEF    = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    PLAY = 2'd2
  } state_e;

  function automatic logic [2:0] mode_mask(logic [1:0] mode);
    case (mode)
      MODE_TUNER: return 3'b001;
      MODE_METRO: return 3'b010;
      MODE_COMP:  return 3'b110;
      default:    return 3'b000;
    endcase
  endfunction

  // Metronome beats tuner beats composer; only meaningful when elig != 0.
  function automatic logic [1:0] pick_winner(logic [2:0] elig);
    if (elig[SRC_M])      return SRC_M;
    else if (elig[SRC_T]) return SRC_T;
    else                  return SRC_C;
  endfunction

endpackage

// File: rtl/speaker_arbiter_gap_timer.sv
// Down-counter for the muted gap: load takes priority over dec, stops at zero.
module speaker_arbiter_gap_timer #(
  parameter int GAP_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(GAP_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/speaker_arbiter.sv
// Picks one tone source for the shared PWM speaker and mutes a fixed gap on
// every ownership change so switching never clicks.
//
// state | meaning
// IDLE  | no eligible request, speaker at rest, amp off
// GAP   | owner chosen, amp muted while the gap timer runs
// PLAY  | owner's tone routed to the speaker, amp on
module speaker_arbiter
  import speaker_arbiter_pkg::*;
#(
  parameter int         GAP_CYCLES = 100000,
  parameter logic [3:0] REST_FREQ  = REST_FREQ_DEF,
  parameter logic [2:0] REST_H     = REST_H_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic [2:0] req,
  input  logic [3:0] freq_t,
  input  logic [3:0] freq_m,
  input  logic [3:0] freq_c,
  input  logic [2:0] h_t,
  input  logic [2:0] h_m,
  input  logic [2:0] h_c,
  output logic [3:0] freq_out,
  output logic [2:0] h_out,
  output logic       amp_en,
  output logic [2:0] grant,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [2:0] elig;
  logic [1:0] win;
  logic       tmr_load, tmr_dec, tmr_done;
  logic       play_hold;
  logic [3:0] sel_freq;
  logic [2:0] sel_h;

  speaker_arbiter_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tmr_load),
    .dec  (tmr_dec),
    .done (tmr_done)
  );

  always_comb begin
    elig     = req & mode_mask(mode);
    win      = pick_winner(elig);
    state_d  = state_q;
    owner_d  = owner_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (elig != 3'b000) begin
          owner_d  = win;
          tmr_load = 1'b1;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (elig == 3'b000) begin
          state_d = IDLE;
        end else if (win != owner_q) begin
          owner_d  = win;
          tmr_load = 1'b1;
        end else if (tmr_done) begin
          state_d = PLAY;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      PLAY: begin
        // Owner dropping out or being outranked both show up as a new winner.
        if (elig == 3'b000) begin
          state_d = IDLE;
        end else if (win != owner_q) begin
          owner_d  = win;
          tmr_load = 1'b1;
          state_d  = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= SRC_T;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    case (owner_q)
      SRC_T:   begin sel_freq = freq_t; sel_h = h_t; end
      SRC_M:   begin sel_freq = freq_m; sel_h = h_m; end
      default: begin sel_freq = freq_c; sel_h = h_c; end
    endcase
    // Tone only leaves the block once PLAY has been held for a full cycle,
    // and drops back to rest on the same edge that leaves PLAY.
    play_hold = (state_q == PLAY) && (state_d == PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_out <= REST_FREQ;
      h_out    <= REST_H;
      amp_en   <= 1'b0;
      grant    <= 3'b000;
      busy     <= 1'b0;
    end else begin
      freq_out <= play_hold ? sel_freq : REST_FREQ;
      h_out    <= play_hold ? sel_h : REST_H;
      amp_en   <= play_hold;
      grant    <= (state_d == IDLE) ? 3'b000 : (3'b001 << owner_d);
      busy     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_speaker_arbiter.sv
// Directed scoreboard bench for speaker_arbiter with a short gap.
`timescale 1ns/1ps
module tb_speaker_arbiter;

   localparam int G = 4;
   localparam logic [11:0] REST_V = {4'hC, 3'd2, 1'b0, 3'b000, 1'b0};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [2:0] req = 3'b000;
   logic [3:0] freq_t = 4'd3, freq_m = 4'd9, freq_c = 4'd5;
   logic [2:0] h_t = 3'd4, h_m = 3'd1, h_c = 3'd6;
   logic [3:0] freq_out;
   logic [2:0] h_out;
   logic       amp_en;
   logic [2:0] grant;
   logic       busy;

   speaker_arbiter #(.GAP_CYCLES(G)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .req(req),
      .freq_t(freq_t), .freq_m(freq_m), .freq_c(freq_c),
      .h_t(h_t), .h_m(h_m), .h_c(h_c),
      .freq_out(freq_out), .h_out(h_out), .amp_en(amp_en),
      .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          at;
      string       name;
      logic [11:0] v;
   } exp_t;
   exp_t sb[$];

   int tests = 0;
   int failed = 0;

   function automatic logic [11:0] gapv(logic [2:0] g);
      return {4'hC, 3'd2, 1'b0, g, 1'b1};
   endfunction

   function automatic logic [11:0] playv(logic [3:0] f, logic [2:0] h, logic [2:0] g);
      return {f, h, 1'b1, g, 1'b1};
   endfunction

   task automatic push(int at, string name, logic [11:0] v);
      exp_t e;
      e.at = at;
      e.name = name;
      e.v = v;
      sb.push_back(e);
   endtask

   task automatic push_gap(int from, int to, string name, logic [2:0] g);
      for (int k = from; k <= to; k++) push(k, name, gapv(g));
   endtask

   task automatic tick(int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Monitor: compare every expectation due this cycle, away from the rising edge.
   always @(negedge clk) begin
      logic [11:0] act;
      act = {freq_out, h_out, amp_en, grant, busy};
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at <= cyc) begin
            tests++;
            if (sb[i].at < cyc || act !== sb[i].v) begin
               failed++;
               $display("FAIL %s @cyc %0d (due %0d): freq/h/amp/grant/busy got %h/%h/%b/%b/%b expected %h/%h/%b/%b/%b",
                        sb[i].name, cyc, sb[i].at,
                        act[11:8], act[7:5], act[4], act[3:1], act[0],
                        sb[i].v[11:8], sb[i].v[7:5], sb[i].v[4], sb[i].v[3:1], sb[i].v[0]);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, %0d tests run", tests);
      $fatal(1, "timeout");
   end

   initial begin
      int n, m, e, p, q, s, t;
      tick(3);
      rst_n = 1'b1;
      n = cyc;
      push(n, "reset", REST_V);
      push(n + 1, "reset_idle", REST_V);
      tick(2);

      // Basic tuner play, then live note change and release.
      n = cyc;
      mode = 2'b01; req = 3'b001;
      push_gap(n + 1, n + G + 1, "basic_gap", 3'b001);
      push(n + G + 2, "basic_play", playv(4'd3, 3'd4, 3'b001));
      tick(G + 3);
      freq_t = 4'd7;
      push(n + 7, "live_old", playv(4'd3, 3'd4, 3'b001));
      push(n + 8, "live_new", playv(4'd7, 3'd4, 3'b001));
      tick(2);
      req = 3'b000;
      push(n + 9, "drop_last", playv(4'd7, 3'd4, 3'b001));
      push(n + 10, "drop_idle", REST_V);
      tick(3);
      freq_t = 4'd3;

      // Pulse shorter than the gap never reaches the amplifier.
      n = cyc;
      req = 3'b001;
      push_gap(n + 1, n + 2, "pulse_gap", 3'b001);
      tick(2);
      req = 3'b000;
      for (int k = 3; k <= 8; k++) push(n + k, "pulse_idle", REST_V);
      tick(8);

      // Mode mask: tuner mode ignores metronome/composer requests.
      n = cyc;
      req = 3'b110; mode = 2'b01;
      push(n + 1, "mask_tuner", REST_V);
      push(n + 2, "mask_tuner", REST_V);
      tick(3);
      m = cyc;
      mode = 2'b10;
      push_gap(m + 1, m + G + 1, "mask_metro_gap", 3'b010);
      push(m + G + 2, "mask_metro_play", playv(4'd9, 3'd1, 3'b010));
      tick(G + 3);
      req = 3'b000;
      push(m + 7, "metro_last", playv(4'd9, 3'd1, 3'b010));
      push(m + 8, "metro_idle", REST_V);
      tick(3);

      // Idle mode grants nothing.
      n = cyc;
      mode = 2'b00; req = 3'b111;
      push(n + 1, "mode_idle", REST_V);
      push(n + 2, "mode_idle", REST_V);
      tick(3);

      // Composer mode: composer plays, metronome preempts, composer returns.
      e = cyc;
      mode = 2'b11; req = 3'b100;
      push_gap(e + 1, e + G + 1, "comp_gap", 3'b100);
      push(e + G + 2, "comp_play", playv(4'd5, 3'd6, 3'b100));
      tick(G + 3);
      p = cyc;
      req = 3'b110;
      push(p, "pre_before", playv(4'd5, 3'd6, 3'b100));
      push_gap(p + 1, p + G + 1, "preempt_gap", 3'b010);
      push(p + G + 2, "preempt_play", playv(4'd9, 3'd1, 3'b010));
      tick(G + 3);
      q = cyc;
      req = 3'b100;
      push_gap(q + 1, q + G + 1, "regain_gap", 3'b100);
      push(q + G + 2, "regain_play", playv(4'd5, 3'd6, 3'b100));
      tick(G + 3);
      req = 3'b101;
      push(q + G + 4, "tuner_masked", playv(4'd5, 3'd6, 3'b100));
      tick(2);

      // Winner change inside GAP restarts the full gap.
      req = 3'b000;
      push(cyc + 1, "restart_pre_idle", REST_V);
      tick(2);
      s = cyc;
      req = 3'b100;
      push_gap(s + 1, s + 2, "restart_gap_c", 3'b100);
      tick(2);
      req = 3'b110;
      push_gap(s + 3, s + G + 3, "restart_gap_m", 3'b010);
      push(s + G + 4, "restart_play", playv(4'd9, 3'd1, 3'b010));
      tick(G + 3);

      // Async reset while playing mutes before the next rising edge.
      t = cyc;
      push(t, "async_reset", REST_V);
      push(t + 1, "async_reset_hold", REST_V);
      rst_n = 1'b0;
      req = 3'b000;
      #1;
      tests++;
      if (amp_en !== 1'b0) begin
         failed++;
         $display("FAIL async_amp: amp_en %b before clk edge", amp_en);
      end
      tests++;
      if (freq_out !== 4'hC) begin
         failed++;
         $display("FAIL async_freq: freq_out %h before clk edge", freq_out);
      end
      tests++;
      if (h_out !== 3'd2) begin
         failed++;
         $display("FAIL async_h: h_out %h before clk edge", h_out);
      end
      tests++;
      if (grant !== 3'b000) begin
         failed++;
         $display("FAIL async_grant: grant %b before clk edge", grant);
      end
      tests++;
      if (busy !== 1'b0) begin
         failed++;
         $display("FAIL async_busy: busy %b before clk edge", busy);
      end
      tick(2);
      rst_n = 1'b1;
      push(cyc + 1, "after_reset", REST_V);
      tick(3);

      foreach (sb[i]) begin
         tests++;
         failed++;
         $display("FAIL %s: expected at cyc %0d never checked", sb[i].name, sb[i].at);
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
